fp_addition: RTL and testbench

- Pipelined IEEE-754 single-precision floating-point adder; the add/subtract datapath of the configurable FPU (fpu top).
- Accepts one operand pair per clock when enabled; produces the rounded sum (round-to-nearest-even) a fixed 3 cycles later.
- Subtraction is done upstream by flipping opb's sign bit.

---
 rtl/fp_addition.sv | 120 ++++++++++++
 tb/tb_fp_addition.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fp_addition.sv
// fp_addition: pipelined binary32 adder (unpack/align, add/sub, normalize, round/pack), round-to-nearest-even
module fp_addition #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic [WIDTH-1:0] out,
    output logic             out_valid
);
    logic               a_z, b_z, a_nan, b_nan, a_inf, b_inf, swap, sp_n;
    logic [30:0]        mag_a, mag_b;
    logic [31:0]        big, sml, spv_n;
    logic [23:0]        sig_l, sig_s;
    logic [7:0]         d;
    logic [4:0]         sh;
    logic [49:0]        ext;
    logic [LATENCY-1:0] vp;
    logic               sa1, sb1, zs1, sp1;
    logic [7:0]         e1;
    logic [26:0]        ma1, mb1;
    logic [31:0]        spv1;
    logic               s2, zs2, sp2;
    logic [7:0]         e2;
    logic [27:0]        m2;
    logic [31:0]        spv2;
    logic [4:0]         lz;
    logic [26:0]        n_n;
    logic signed [9:0]  exp_n;
    logic               s3, z3, zs3, sp3;
    logic signed [9:0]  e3, ef;
    logic [26:0]        n3;
    logic [31:0]        spv3, res;
    logic               rup;
    logic [24:0]        rs;
    logic [22:0]        frac;

    // Stage 1: denormals become zero magnitude, larger magnitude goes to the A side
    always_comb begin
        a_z   = opa[30:23] == 8'd0;
        b_z   = opb[30:23] == 8'd0;
        a_nan = opa[30:23] == 8'hff && opa[22:0] != 23'd0;
        b_nan = opb[30:23] == 8'hff && opb[22:0] != 23'd0;
        a_inf = opa[30:23] == 8'hff && opa[22:0] == 23'd0;
        b_inf = opb[30:23] == 8'hff && opb[22:0] == 23'd0;
        mag_a = a_z ? 31'd0 : opa[30:0];
        mag_b = b_z ? 31'd0 : opb[30:0];
        swap  = mag_b > mag_a;
        big   = swap ? {opb[31], mag_b} : {opa[31], mag_a};
        sml   = swap ? {opa[31], mag_a} : {opb[31], mag_b};
        sig_l = big[30:23] == 8'd0 ? 24'd0 : {1'b1, big[22:0]};
        sig_s = sml[30:23] == 8'd0 ? 24'd0 : {1'b1, sml[22:0]};
        d     = big[30:23] - sml[30:23];
        sh    = d > 8'd26 ? 5'd26 : d[4:0];
        ext   = {sig_s, 26'd0} >> sh;
        sp_n  = a_nan | b_nan | a_inf | b_inf;
        spv_n = (a_nan | b_nan | (a_inf & b_inf & (opa[31] ^ opb[31]))) ? 32'h7fc00000 :
                a_inf ? opa : opb;
    end

    // Stage 3a: normalize, sticky folded in on carry-out
    always_comb begin
        lz = 5'd27;
        for (int i = 0; i < 27; i++)
            if (m2[i]) lz = 5'(26 - i);
        n_n   = m2[27] ? {m2[27:2], |m2[1:0]} : m2[26:0] << lz;
        exp_n = m2[27] ? $signed({2'b0, e2}) + 10'sd1 : $signed({2'b0, e2}) - $signed({5'b0, lz});
    end

    // Stage 3b: round to nearest even, then pack with zero/underflow/overflow handling
    always_comb begin
        rup  = n3[2] & (n3[1] | n3[0] | n3[3]);
        rs   = {1'b0, n3[26:3]} + {24'd0, rup};
        ef   = e3 + $signed({9'd0, rs[24]});
        frac = rs[24] ? rs[23:1] : rs[22:0];
        res  = sp3 ? spv3 :
               z3 ? {zs3, 31'd0} :
               e3 <= 10'sd0 ? {s3, 31'd0} :
               ef >= 10'sd255 ? {s3, 8'hff, 23'd0} : {s3, ef[7:0], frac};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vp <= '0;
            {sa1, sb1, zs1, sp1, e1, ma1, mb1, spv1} <= '0;
            {s2, zs2, sp2, e2, m2, spv2} <= '0;
            {s3, z3, zs3, sp3, e3, n3, spv3} <= '0;
            out <= '0;
            out_valid <= 1'b0;
        end else begin
            vp   <= {vp[LATENCY-2:0], en};
            sa1  <= big[31];
            sb1  <= sml[31];
            zs1  <= opa[31] & opb[31];
            sp1  <= sp_n;
            spv1 <= spv_n;
            e1   <= big[30:23];
            ma1  <= {sig_l, 3'd0};
            mb1  <= {ext[49:24], |ext[23:0]};
            s2   <= sa1;
            zs2  <= zs1;
            sp2  <= sp1;
            spv2 <= spv1;
            e2   <= e1;
            m2   <= sa1 == sb1 ? {1'b0, ma1} + {1'b0, mb1} : {1'b0, ma1} - {1'b0, mb1};
            s3   <= s2;
            z3   <= m2 == 28'd0;
            zs3  <= zs2;
            sp3  <= sp2;
            spv3 <= spv2;
            e3   <= exp_n;
            n3   <= n_n;
            out_valid <= vp[LATENCY-1];
            if (vp[LATENCY-1]) out <= res;
        end
    end
endmodule

// File: tb/tb_fp_addition.sv
// tb_fp_addition: directed table, streaming random checks against an exact-integer model, and reset corner cases
module tb_fp_addition;
    logic        clk = 1'b0;
    logic        rst_n, en;
    logic [31:0] opa, opb, out;
    logic        out_valid;
    int          n_chk = 0, n_fail = 0;
    logic [31:0] sa [256], sb [256], se [256];

    typedef struct {
        logic [31:0] a, b, y;
    } vec_t;
    vec_t tbl [14];

    fp_addition dut (.clk(clk), .rst_n(rst_n), .en(en), .opa(opa), .opb(opb), .out(out), .out_valid(out_valid));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Value scaled to integer units with plenty of bits below the rounding point; lost bits kept as an odd LSB
    function automatic longint scaled(input longint m, input int s);
        longint lost;
        if (m == 0) return 0;
        if (s >= 0) return m << s;
        if (-s > 40) return 1;
        lost = m & ((64'sd1 << -s) - 1);
        return (m >> -s) | longint'(lost != 0);
    endfunction

    function automatic logic [31:0] model_add(input logic [31:0] a, input logic [31:0] b);
        bit     an, bn, ai, bi, sg;
        int     ea, eb, base, p, e, shr;
        longint ma, mb, s, mag, q, rem, half;
        an = a[30:23] == 8'hff && a[22:0] != 0;
        bn = b[30:23] == 8'hff && b[22:0] != 0;
        ai = a[30:23] == 8'hff && a[22:0] == 0;
        bi = b[30:23] == 8'hff && b[22:0] == 0;
        if (an || bn) return 32'h7fc00000;
        if (ai && bi) return a[31] == b[31] ? a : 32'h7fc00000;
        if (ai) return a;
        if (bi) return b;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        ma = ea == 0 ? 0 : longint'({1'b1, a[22:0]});
        mb = eb == 0 ? 0 : longint'({1'b1, b[22:0]});
        base = (ea > eb ? ea : eb) - 38;
        s = (a[31] ? -scaled(ma, ea - base) : scaled(ma, ea - base)) +
            (b[31] ? -scaled(mb, eb - base) : scaled(mb, eb - base));
        if (s == 0) return {a[31] & b[31], 31'd0};
        sg  = s < 0;
        mag = sg ? -s : s;
        p = 0;
        for (int i = 0; i < 63; i++) if (mag[i]) p = i;
        e = p + base - 23;
        if (e <= 0) return {sg, 31'd0};
        if (p > 23) begin
            shr  = p - 23;
            q    = mag >> shr;
            rem  = mag & ((64'sd1 << shr) - 1);
            half = 64'sd1 << (shr - 1);
            if (rem > half || (rem == half && q[0])) q++;
            if (q == (64'sd1 << 24)) begin
                q = q >> 1;
                e++;
            end
        end else q = mag << (23 - p);
        if (e >= 255) return {sg, 8'hff, 23'd0};
        return {sg, e[7:0], q[22:0]};
    endfunction

    function automatic logic [31:0] rnd_fp();
        int k;
        logic [7:0] e;
        k = $urandom_range(0, 15);
        if (k == 0) begin
            case ($urandom_range(0, 7))
                0: return 32'h00000000;
                1: return 32'h80000000;
                2: return 32'h7f800000;
                3: return 32'hff800000;
                4: return 32'h7fc00000;
                5: return 32'h00000001;
                6: return 32'h7f7fffff;
                default: return 32'h00800000;
            endcase
        end
        e = k == 1 ? 8'($urandom_range(1, 3)) : k == 2 ? 8'($urandom_range(252, 254)) : 8'($urandom_range(110, 150));
        return {1'($urandom_range(0, 1)), e, 23'($urandom)};
    endfunction

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) begin
            sa[i] = rnd_fp();
            sb[i] = $urandom_range(0, 3) == 0 ? {~sa[i][31], sa[i][30:0] ^ 31'($urandom_range(0, 255))} : rnd_fp();
            se[i] = model_add(sa[i], sb[i]);
        end
    endtask

    // Op i is sampled at edge i+1 and must show up exactly after edge i+4, then hold
    task automatic run_stream(input int n);
        for (int c = 1; c <= n + 6; c++) begin
            en  = c - 1 < n;
            opa = c - 1 < n ? sa[c-1] : 32'd0;
            opb = c - 1 < n ? sb[c-1] : 32'd0;
            @(posedge clk);
            #1;
            check($sformatf("out_valid@%0d", c), 32'(out_valid), (c >= 4 && c - 4 < n) ? 32'd1 : 32'd0);
            if (c >= 4 && c - 4 < n) check($sformatf("out[%0d] %h+%h", c - 4, sa[c-4], sb[c-4]), out, se[c-4]);
            else if (c - 4 >= n) check($sformatf("hold@%0d", c), out, se[n-1]);
        end
        en = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{32'h40800000, 32'h43560000, 32'h435a0000};
        tbl[1]  = '{32'h3f800000, 32'hbf800000, 32'h00000000};
        tbl[2]  = '{32'h80000000, 32'h80000000, 32'h80000000};
        tbl[3]  = '{32'h3f800000, 32'h00000001, 32'h3f800000};
        tbl[4]  = '{32'h3f800000, 32'h33800000, 32'h3f800000};
        tbl[5]  = '{32'h3f800000, 32'h34000000, 32'h3f800001};
        tbl[6]  = '{32'h3f800001, 32'h33800000, 32'h3f800002};
        tbl[7]  = '{32'h7f800000, 32'hff800000, 32'h7fc00000};
        tbl[8]  = '{32'h7fc00001, 32'h3f800000, 32'h7fc00000};
        tbl[9]  = '{32'h7f7fffff, 32'h7f7fffff, 32'h7f800000};
        tbl[10] = '{32'hff800000, 32'h42280000, 32'hff800000};
        tbl[11] = '{32'h3f800001, 32'hbf800000, 32'h34000000};
        tbl[12] = '{32'h00800000, 32'h80800001, 32'h80000000};
        tbl[13] = '{32'h80000000, 32'h00000000, 32'h00000000};
        rst_n = 1'b0;
        en    = 1'b0;
        opa   = '0;
        opb   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset out", out, 32'd0);
        check("reset out_valid", 32'(out_valid), 32'd0);
        rst_n = 1'b1;
        sa[0] = tbl[0].a;
        sb[0] = tbl[0].b;
        se[0] = tbl[0].y;
        run_stream(1);
        for (int i = 0; i < 14; i++) begin
            sa[2*i]   = tbl[i].a;
            sb[2*i]   = tbl[i].b;
            se[2*i]   = tbl[i].y;
            sa[2*i+1] = tbl[i].b;
            sb[2*i+1] = tbl[i].a;
            se[2*i+1] = tbl[i].y;
        end
        run_stream(28);
        fill_random(5);
        run_stream(5);
        fill_random(200);
        run_stream(200);
        fill_random(5);
        for (int c = 1; c <= 5; c++) begin
            en  = 1'b1;
            opa = sa[c-1];
            opb = sb[c-1];
            @(posedge clk);
            #1;
        end
        check("pre-reset out_valid", 32'(out_valid), 32'd1);
        check("pre-reset out", out, se[1]);
        en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async reset out", out, 32'd0);
        check("async reset out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("stale valid@%0d", c), 32'(out_valid), 32'd0);
            check($sformatf("stale out@%0d", c), out, 32'd0);
        end
        fill_random(3);
        run_stream(3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
